// File: rtl/lifo_arbiter_if.sv
// Bundle of signals between the lifo_arbiter, its requesters and the LIFO.
// The slave modport is the arbiter's view. The master modport is the view
// of the environment: the clients plus the LIFO.
interface lifo_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 10,
  parameter int LIFO_SIZE = 6
);
  localparam int CNT_W = $clog2(LIFO_SIZE);

  logic [NUM_REQ-1:0]        push_req;
  logic [NUM_REQ-1:0]        pop_req;
  logic [NUM_REQ*DATA_W-1:0] push_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      err;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      lifo_write;
  logic                      lifo_read;
  logic [DATA_W-1:0]         lifo_datain;
  logic [DATA_W-1:0]         lifo_dataout;
  logic                      lifo_val;
  logic [CNT_W-1:0]          count;

  modport slave (
    input  push_req, pop_req, push_data, lifo_dataout, lifo_val,
    output ack, err, rsp_valid, rsp_data, lifo_write, lifo_read, lifo_datain, count
  );

  modport master (
    output push_req, pop_req, push_data, lifo_dataout, lifo_val,
    input  ack, err, rsp_valid, rsp_data, lifo_write, lifo_read, lifo_datain, count
  );
endinterface

// File: rtl/lifo_arbiter.sv
// lifo_arbiter: round-robin arbitration of NUM_REQ push/pop requesters onto a
// single shared LIFO. Occupancy is tracked locally, so overflow and underflow
// are rejected with err before they reach the stack. Popped data is routed
// back to the requester that was granted.
// Optional statistics ports (rej_count, max_count) exist when the macro
// LIFO_ARB_STATS_EN is defined.
module lifo_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 10,
  parameter int LIFO_SIZE = 6
) (
  input  logic                         clock,
  input  logic                         reset,
  lifo_arbiter_if.slave                bus
`ifdef LIFO_ARB_STATS_EN
  ,
  output logic [15:0]                  rej_count,
  output logic [$clog2(LIFO_SIZE)-1:0] max_count
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LIFO_SIZE);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(LIFO_SIZE - 1);

  typedef enum logic [1:0] {IDLE, CMD, RSP} state_t;

  state_t              state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    winner;
  logic                pop_ok;
  logic [NUM_REQ-1:0]  ack_r;
  logic                err_r;
  logic [NUM_REQ-1:0]  rsp_valid_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic                wr_r;
  logic                rd_r;
  logic [DATA_W-1:0]   din_r;
  logic [CNT_W-1:0]    count_r;

  logic [NUM_REQ-1:0]  req;
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    cand;
  logic [DATA_W-1:0]   win_data;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  assign req = bus.push_req | bus.pop_req;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Select the push data slice of the current winner.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) win_data = bus.push_data[i*DATA_W +: DATA_W];
    end
  end

  // Arbitration FSM. Grants happen on the IDLE edge, so ack and the LIFO
  // strobes are visible during CMD. Popped data is sampled at the end of RSP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= IDX_W'(NUM_REQ - 1);
      winner      <= '0;
      pop_ok      <= 1'b0;
      ack_r       <= '0;
      err_r       <= 1'b0;
      rsp_valid_r <= '0;
      rsp_data_r  <= '0;
      wr_r        <= 1'b0;
      rd_r        <= 1'b0;
      din_r       <= '0;
      count_r     <= '0;
    end else begin
      ack_r       <= '0;
      err_r       <= 1'b0;
      rsp_valid_r <= '0;
      wr_r        <= 1'b0;
      rd_r        <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            rr_ptr <= win_idx;
            winner <= win_idx;
            ack_r  <= onehot(win_idx);
            pop_ok <= 1'b0;
            state  <= CMD;
            if (bus.pop_req[win_idx]) begin
              // A pop takes priority over a push from the same requester.
              if (count_r == '0) begin
                err_r <= 1'b1;
              end else begin
                rd_r    <= 1'b1;
                count_r <= count_r - 1'b1;
                pop_ok  <= 1'b1;
              end
            end else begin
              if (count_r == CAP) begin
                err_r <= 1'b1;
              end else begin
                wr_r    <= 1'b1;
                din_r   <= win_data;
                count_r <= count_r + 1'b1;
              end
            end
          end
        end
        CMD: state <= pop_ok ? RSP : IDLE;
        RSP: begin
          rsp_valid_r <= onehot(winner);
          rsp_data_r  <= bus.lifo_val ? bus.lifo_dataout : '0;
          err_r       <= ~bus.lifo_val;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack         = ack_r;
  assign bus.err         = err_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_data    = rsp_data_r;
  assign bus.lifo_write  = wr_r;
  assign bus.lifo_read   = rd_r;
  assign bus.lifo_datain = din_r;
  assign bus.count       = count_r;

`ifdef LIFO_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Rejection counter (saturating) and occupancy high-water mark.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rej_count <= '0;
      max_count <= '0;
    end else begin
      if (err_r) rej_count <= sat_inc(rej_count);
      if (count_r > max_count) max_count <= count_r;
    end
  end
`endif

endmodule

// File: tb/tb_lifo_arbiter.sv
// Testbench for lifo_arbiter. It contains a behavioural LIFO and a
// transaction-level reference model built on a queue.
module tb_lifo_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 10;
  localparam int LIFO_SIZE = 6;
  localparam int CAP       = LIFO_SIZE - 1;

  logic clock;
  logic reset;
  bit   drop_val;
  bit   mon_en;
  int   n_tests;
  int   n_fail;

  lifo_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LIFO_SIZE(LIFO_SIZE)) bus ();

`ifdef LIFO_ARB_STATS_EN
  logic [15:0]                  rej_count;
  logic [$clog2(LIFO_SIZE)-1:0] max_count;
`endif

  lifo_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LIFO_SIZE(LIFO_SIZE)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef LIFO_ARB_STATS_EN
    ,
    .rej_count(rej_count),
    .max_count(max_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural stand-in for the LIFO: read data appears the cycle after the strobe.
  logic [DATA_W-1:0] lq[$];
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      lq.delete();
      bus.lifo_dataout <= '0;
      bus.lifo_val     <= 1'b0;
    end else begin
      bus.lifo_val <= 1'b0;
      if (bus.lifo_write) lq.push_back(bus.lifo_datain);
      if (bus.lifo_read && lq.size() > 0) begin
        bus.lifo_dataout <= lq.pop_back();
        bus.lifo_val     <= !drop_val;
      end
    end
  end

  // Reference model: occupancy is the size of a queue. Each transaction is
  // a grant (ack next cycle). A successful pop adds a hold cycle and then a
  // response cycle.
  int                 m_phase;
  int                 m_rr;
  int                 m_win;
  int                 m_w;
  bit                 m_pend;
  bit                 m_drop;
  logic [DATA_W-1:0]  m_val;
  logic [DATA_W-1:0]  m_stk[$];
  logic [NUM_REQ-1:0] e_ack;
  logic [NUM_REQ-1:0] e_rv;
  bit                 e_err;
  bit                 e_wr;
  bit                 e_rd;
  logic [DATA_W-1:0]  e_din;
  logic [DATA_W-1:0]  e_rdata;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_rr = NUM_REQ - 1; m_win = 0; m_pend = 0; m_drop = 0; m_val = '0;
      m_stk.delete();
      e_ack = '0; e_rv = '0; e_err = 0; e_wr = 0; e_rd = 0; e_din = '0; e_rdata = '0;
    end else begin
      e_ack = '0; e_rv = '0; e_err = 0; e_wr = 0; e_rd = 0;
      if (m_phase == 0) begin
        m_w = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (m_w < 0 && (bus.push_req[(m_rr + k) % NUM_REQ] || bus.pop_req[(m_rr + k) % NUM_REQ]))
            m_w = (m_rr + k) % NUM_REQ;
        end
        if (m_w >= 0) begin
          m_rr = m_w; m_win = m_w; m_pend = 0; m_phase = 1;
          e_ack = NUM_REQ'(1) << m_w;
          if (bus.pop_req[m_w]) begin
            if (m_stk.size() == 0) e_err = 1;
            else begin e_rd = 1; m_val = m_stk.pop_back(); m_pend = 1; end
          end else begin
            if (m_stk.size() == CAP) e_err = 1;
            else begin
              e_wr = 1;
              e_din = bus.push_data[m_w*DATA_W +: DATA_W];
              m_stk.push_back(e_din);
            end
          end
        end
      end else if (m_phase == 1) begin
        m_drop  = drop_val;
        m_phase = m_pend ? 2 : 0;
      end else begin
        e_rv    = NUM_REQ'(1) << m_win;
        e_rdata = m_drop ? '0 : m_val;
        e_err   = m_drop;
        m_phase = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (mon_en) begin
      chk("ack", 32'(bus.ack), 32'(e_ack));
      chk("err", 32'(bus.err), 32'(e_err));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
      chk("lifo_write", 32'(bus.lifo_write), 32'(e_wr));
      chk("lifo_read", 32'(bus.lifo_read), 32'(e_rd));
      chk("count", 32'(bus.count), 32'(m_stk.size()));
      if (bus.lifo_write && bus.lifo_read) chk("wr_rd_excl", 32'd1, 32'd0);
      if (e_wr) chk("lifo_datain", 32'(bus.lifo_datain), 32'(e_din));
      if (e_rv != '0) chk("rsp_data", 32'(bus.rsp_data), 32'(e_rdata));
    end
  end

  task automatic wait_ack(input int i, output bit ok);
    ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clock);
      if (bus.ack[i]) ok = 1;
    end
    if (!ok) chk($sformatf("ack_timeout_%0d", i), 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1;
    reset = 1'b0;
    bus.push_req = '0;
    bus.pop_req  = '0;
    drop_val     = 0;
    repeat (2) @(negedge clock);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_datain", 32'(bus.lifo_datain), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
`ifdef LIFO_ARB_STATS_EN
    chk("rst_rej_count", 32'(rej_count), 32'd0);
    chk("rst_max_count", 32'(max_count), 32'd0);
`endif
    #1;
    reset = 1'b1;
  endtask

  task automatic do_push(input int i, input logic [DATA_W-1:0] d);
    bit ok;
    bus.push_data[i*DATA_W +: DATA_W] = d;
    bus.push_req[i] = 1'b1;
    wait_ack(i, ok);
    bus.push_req[i] = 1'b0;
  endtask

  initial begin
    bit ok;
    int got;
    int bias;
    reset         = 1'b0;
    mon_en        = 0;
    drop_val      = 0;
    n_tests       = 0;
    n_fail        = 0;
    bus.push_req  = '0;
    bus.pop_req   = '0;
    bus.push_data = '0;
    repeat (2) @(posedge clock);
    mon_en = 1;

    // Single push.
    do_reset();
    do_push(0, 10'h2A5);
    chk("t1_ack", 32'(bus.ack), 32'h1);
    chk("t1_write", 32'(bus.lifo_write), 32'd1);
    chk("t1_datain", 32'(bus.lifo_datain), 32'h2A5);
    chk("t1_err", 32'(bus.err), 32'd0);
    chk("t1_count", 32'(bus.count), 32'd1);

    // LIFO order through a different requester.
    do_reset();
    for (int v = 1; v <= 3; v++) do_push(0, DATA_W'(v));
    bus.pop_req[2] = 1'b1;
    wait_ack(2, ok);
    bus.pop_req[2] = 1'b0;
    chk("t2_read", 32'(bus.lifo_read), 32'd1);
    chk("t2_count", 32'(bus.count), 32'd2);
    repeat (2) @(negedge clock);
    chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'h4);
    chk("t2_rsp_data", 32'(bus.rsp_data), 32'd3);

    // Round-robin order from reset.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) bus.push_data[i*DATA_W +: DATA_W] = DATA_W'(i + 8);
    bus.push_req = '1;
    for (int k = 0; k < NUM_REQ; k++) begin
      got = -1;
      for (int n = 0; n < 20 && got < 0; n++) begin
        @(negedge clock);
        for (int i = 0; i < NUM_REQ; i++) if (bus.ack[i]) got = i;
      end
      chk("t3_rr_order", 32'(got), 32'(k));
      if (got >= 0) bus.push_req[got] = 1'b0;
    end
    bus.push_req = '0;
    chk("t3_count", 32'(bus.count), 32'd4);

    // Overflow rejection.
    do_reset();
    for (int v = 0; v < CAP; v++) do_push(0, DATA_W'(v + 100));
    do_push(1, 10'h3FF);
    chk("t4_ack", 32'(bus.ack), 32'h2);
    chk("t4_err", 32'(bus.err), 32'd1);
    chk("t4_write", 32'(bus.lifo_write), 32'd0);
    chk("t4_count", 32'(bus.count), 32'(CAP));
    @(negedge clock);
`ifdef LIFO_ARB_STATS_EN
    chk("t4_rej_count", 32'(rej_count), 32'd1);
    chk("t4_max_count", 32'(max_count), 32'(CAP));
`endif

    // Underflow rejection.
    do_reset();
    bus.pop_req[0] = 1'b1;
    wait_ack(0, ok);
    bus.pop_req[0] = 1'b0;
    chk("t5_err", 32'(bus.err), 32'd1);
    chk("t5_read", 32'(bus.lifo_read), 32'd0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      chk("t5_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
`ifdef LIFO_ARB_STATS_EN
    chk("t5_rej_count", 32'(rej_count), 32'd1);
`endif

    // Reset during the RSP cycle of a pop.
    do_reset();
    do_push(0, 10'h11);
    do_push(0, 10'h22);
    bus.pop_req[3] = 1'b1;
    wait_ack(3, ok);
    bus.pop_req[3] = 1'b0;
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t6_count", 32'(bus.count), 32'd0);
    chk("t6_ack", 32'(bus.ack), 32'd0);
    @(negedge clock);
    chk("t6_rsp_valid_after", 32'(bus.rsp_valid), 32'd0);
    #1;
    reset = 1'b1;

    // Randomised traffic with phases biased towards full and towards empty.
    do_reset();
    bias = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      if (cyc % 300 == 0) bias = int'($urandom_range(0, 2));
      drop_val = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.ack[i]) begin
          if (bus.pop_req[i]) bus.pop_req[i] = 1'b0;
          else bus.push_req[i] = 1'b0;
        end else if (!bus.push_req[i] && !bus.pop_req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            bus.push_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            case (bias)
              0: if ($urandom_range(0, 3) == 0) bus.pop_req[i] = 1'b1; else bus.push_req[i] = 1'b1;
              1: if ($urandom_range(0, 3) == 0) bus.push_req[i] = 1'b1; else bus.pop_req[i] = 1'b1;
              default: begin
                bus.push_req[i] = 1'($urandom_range(0, 1));
                bus.pop_req[i]  = ~bus.push_req[i] | 1'($urandom_range(0, 1));
              end
            endcase
          end
        end else if ($urandom_range(0, 63) == 0) begin
          bus.push_req[i] = 1'b0;
          bus.pop_req[i]  = 1'b0;
        end
      end
    end
    bus.push_req = '0;
    bus.pop_req  = '0;
    drop_val     = 0;
    repeat (5) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
